mem_arbiter_19bit: RTL

- Two-requester arbiter and sequencer for the 4K x 19-bit unified memory in the CPU.
- Requester 0 is the instruction-fetch path; requester 1 is the load/store path. Both may read or write.
- Grants one access at a time with round-robin fairness. Drives the memory's level-sensitive addr/rd/wr/dataIn for exactly one cycle, registers the read data and returns it with a one-cycle ack.
- Guarantees rd and wr are never high together, and that addr/dataIn are stable for the whole cycle wr is high.

---
 rtl/mem_arbiter_19bit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter_19bit.sv
// Round-robin arbiter/sequencer for the 4K x 19-bit unified memory.
// Two requesters, one access every three cycles, all outputs registered.
module mem_arbiter_19bit #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 19
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_req,
   input  logic              r0_wr,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_ack,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_wr,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_ack,
   output logic [DATA_W-1:0] r1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_dataIn,
   input  logic [DATA_W-1:0] mem_dataOut,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t            state_q;
   logic              last_q;
   logic              win_q;
   logic              dir_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic              rd_q;
   logic              wr_q;
   logic              ack0_q;
   logic              ack1_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;
   logic              busy_q;

   logic              any_d;
   logic              gnt_d;
   logic              wr_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] din_d;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      any_d  = r0_req | r1_req;
      gnt_d  = r1_req & (~r0_req | ~last_q);
      wr_d   = gnt_d ? r1_wr    : r0_wr;
      addr_d = gnt_d ? r1_addr  : r0_addr;
      din_d  = gnt_d ? r1_wdata : r0_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         win_q    <= 1'b0;
         dir_q    <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_d) begin
                  win_q   <= gnt_d;
                  last_q  <= gnt_d;
                  dir_q   <= wr_d;
                  addr_q  <= addr_d;
                  din_q   <= din_d;
                  rd_q    <= ~wr_d;
                  wr_q    <= wr_d;
                  busy_q  <= 1'b1;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (!dir_q) begin
                  if (win_q) rdata1_q <= mem_dataOut;
                  else       rdata0_q <= mem_dataOut;
               end
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
               ack0_q  <= ~win_q;
               ack1_q  <= win_q;
               state_q <= RESP;
            end
            RESP: begin
               ack0_q  <= 1'b0;
               ack1_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign r0_ack     = ack0_q;
   assign r1_ack     = ack1_q;
   assign r0_rdata   = rdata0_q;
   assign r1_rdata   = rdata1_q;
   assign mem_addr   = addr_q;
   assign mem_rd     = rd_q;
   assign mem_wr     = wr_q;
   assign mem_dataIn = din_q;
   assign busy       = busy_q;

endmodule
